jt49_env_ctl: RTL

Control-side driver for the envelope generator. It holds the envelope registers (fine period, coarse period, shape) written over the PSG register bus. It divides the core clock-enable down to the envelope step rate and emits the step strobe, shape bits and restart pulse that the envelope generator consumes. It sits between the register decode and the envelope generator, one instance per PSG.

---
 rtl/jt49_pkg.sv | 31 +++
 rtl/jt49_env_ctl_if.sv | 17 +
 rtl/jt49_env_div.sv | 53 +++++
 rtl/jt49_env_ctl.sv | 81 ++++++++
 4 files changed

// File: rtl/jt49_pkg.sv
// Shared PSG definitions: envelope register addresses, shape bit positions
// and the register-bus payload widths used by the envelope control slice.
package jt49_pkg;

  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned SHAPE_W = 4;

  // Envelope register map
  localparam logic [ADDR_W-1:0] ENV_FINE   = 4'hB;
  localparam logic [ADDR_W-1:0] ENV_COARSE = 4'hC;
  localparam logic [ADDR_W-1:0] ENV_SHAPE  = 4'hD;

  // Bit positions inside the shape register / eg_ctrl
  localparam int unsigned CONT = 3;
  localparam int unsigned ATT  = 2;
  localparam int unsigned ALT  = 1;
  localparam int unsigned HOLD = 0;

  // One register-bus write as seen by the envelope block
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } reg_wr_t;

  // A shape write is the only event that restarts the envelope
  function automatic logic is_restart(input logic wr, input logic [ADDR_W-1:0] addr);
    return wr && (addr == ENV_SHAPE);
  endfunction

endpackage

// File: rtl/jt49_env_ctl_if.sv
// PSG register bus as seen by the envelope control block.
//   wr   : one-cycle write strobe
//   addr : register address
//   din  : write data
//   dout : combinational readback of the register selected by addr
interface jt49_env_ctl_if;
  import jt49_pkg::*;

  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;

  modport master (output wr, output addr, output din, input  dout);
  modport slave  (input  wr, input  addr, input  din, output dout);

endinterface

// File: rtl/jt49_env_div.sv
// Envelope step-rate divider: a free-running prescaler on cen followed by a
// period counter compared against max(period,1).
//   clk, rst_n : clock, async active-low reset
//   cen        : core clock enable, only cen cycles advance the prescaler
//   clr        : synchronous clear of both counters, suppresses any step
//   period     : envelope period, sampled at each compare
//   step       : registered one-cycle step strobe
module jt49_env_div #(
  parameter int unsigned PRESC_W = 4,
  parameter int unsigned PER_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             clr,
  input  logic [PER_W-1:0] period,
  output logic             step
);

  logic [PRESC_W-1:0] presc;
  logic [PER_W-1:0]   cnt;
  logic [PER_W-1:0]   eff_m1_c;
  logic               tick_c;
  logic               term_c;

  // Terminal detect; period 0 behaves as 1, and >= lets a lowered period fire at once
  always_comb begin
    eff_m1_c = '0;
    if (period != '0) eff_m1_c = period - PER_W'(1);
    tick_c = cen && (presc == '1);
    term_c = tick_c && (cnt >= eff_m1_c);
  end

  // Counters and step strobe; clr has priority over any terminal tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      cnt   <= '0;
      step  <= 1'b0;
    end else begin
      step <= term_c && !clr;
      if (clr) begin
        presc <= '0;
        cnt   <= '0;
      end else begin
        if (cen)    presc <= presc + PRESC_W'(1);
        if (term_c) cnt   <= '0;
        else if (tick_c) cnt <= cnt + PER_W'(1);
      end
    end
  end

endmodule

// File: rtl/jt49_env_ctl.sv
// Envelope control: holds fine/coarse period and shape registers written over
// the PSG register bus, drives the step divider and issues the restart pulse.
//   clk, rst_n : clock, async active-low reset
//   cen        : core clock enable
//   bus        : register bus (wr/addr/din in, dout combinational readback)
//   eg_ctrl    : shape bits {CONT,ATT,ALT,HOLD}
//   eg_cen     : registered envelope step strobe
//   eg_restart : registered restart pulse, the cycle after a shape write
//   period     : current period {coarse,fine}
module jt49_env_ctl
  import jt49_pkg::*;
#(
  parameter int unsigned PRESC_W = 4,
  parameter int unsigned PER_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cen,
  jt49_env_ctl_if.slave       bus,
  output logic [SHAPE_W-1:0]  eg_ctrl,
  output logic                eg_cen,
  output logic                eg_restart,
  output logic [PER_W-1:0]    period
);

  localparam int unsigned CRS_W = PER_W - DATA_W;

  logic [DATA_W-1:0]  fine;
  logic [CRS_W-1:0]   coarse;
  logic [SHAPE_W-1:0] shape;
  logic               restart_c;

  assign restart_c = is_restart(bus.wr, bus.addr);
  assign eg_ctrl   = shape;
  assign period    = {coarse, fine};

  // Register file and restart pulse; writes ignore cen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fine       <= '0;
      coarse     <= '0;
      shape      <= '0;
      eg_restart <= 1'b0;
    end else begin
      eg_restart <= restart_c;
      if (bus.wr) begin
        case (bus.addr)
          ENV_FINE:   fine   <= bus.din;
          ENV_COARSE: coarse <= bus.din[CRS_W-1:0];
          ENV_SHAPE:  shape  <= bus.din[SHAPE_W-1:0];
          default:    ;
        endcase
      end
    end
  end

  // Readback mux
  always_comb begin
    bus.dout = '0;
    case (bus.addr)
      ENV_FINE:   bus.dout = fine;
      ENV_COARSE: bus.dout = DATA_W'(coarse);
      ENV_SHAPE:  bus.dout = DATA_W'(shape);
      default:    bus.dout = '0;
    endcase
  end

  // The compare sees the pre-write period because period is registered
  jt49_env_div #(
    .PRESC_W (PRESC_W),
    .PER_W   (PER_W)
  ) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .cen    (cen),
    .clr    (restart_c),
    .period (period),
    .step   (eg_cen)
  );

endmodule
